// File: rtl/srt2_ctrl_if.sv
// Control/status bundle between the SRT radix-2 sequencer and its datapath/ALU top level.
// master = datapath/requester side, slave = the sequencer.
interface srt2_ctrl_if #(
   parameter int unsigned CNT_W = 3
);
   logic             start;
   logic             cnt1;
   logic [CNT_W-1:0] cnt2;
   logic             m7;
   logic [2:0]       ctrl_bits;
   logic [13:0]      c;
   logic             busy;
   logic             done;
   logic             dz;

   modport master (
      output start, cnt1, cnt2, m7, ctrl_bits,
      input  c, busy, done, dz
   );

   modport slave (
      input  start, cnt1, cnt2, m7, ctrl_bits,
      output c, busy, done, dz
   );
endinterface

// File: rtl/srt2_control_unit.sv
// Moore sequencer for the srt2_divider datapath: load, normalize, ITERATIONS SRT radix-2
// steps, correction, quotient formation, un-normalize and output, with start/busy/done.
module srt2_control_unit #(
   parameter int unsigned ITERATIONS = 8,
   parameter int unsigned CNT_W      = 3
) (
   input  logic        clk,
   input  logic        rst_b,
   srt2_ctrl_if.slave  io_bus
);

   localparam int unsigned CTRL_W = 14;
   localparam int unsigned C_LOAD1  = 0;
   localparam int unsigned C_LOAD2  = 1;
   localparam int unsigned C_NORM   = 2;
   localparam int unsigned C_SHIFT  = 3;
   localparam int unsigned C_ADDM   = 4;
   localparam int unsigned C_SUBM   = 5;
   localparam int unsigned C_CORR_A = 6;
   localparam int unsigned C_QFORM  = 7;
   localparam int unsigned C_COUNT  = 8;
   localparam int unsigned C_CORR_B = 9;
   localparam int unsigned C_QSEL   = 10;
   localparam int unsigned C_UNNORM = 11;
   localparam int unsigned C_OUT1   = 12;
   localparam int unsigned C_OUT2   = 13;

   localparam logic [1:0] Q_ZERO = 2'b00;
   localparam logic [1:0] Q_POS  = 2'b01;
   localparam logic [1:0] Q_NEG  = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD1, S_LOAD2, S_NORM, S_CHKM, S_DECIDE, S_SHIFT, S_ADDSUB,
      S_COUNT, S_CORR, S_QFORM, S_UNNORM, S_OUT1, S_OUT2, S_DONE, S_DZERO
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_q;
   logic [1:0]          w_q_nxt;
   logic [CTRL_W-1:0]   r_c;
   logic [CTRL_W-1:0]   w_c_nxt;
   logic                r_busy;
   logic                w_busy_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic                r_dz;
   logic                w_dz_nxt;
   logic                w_last_iter;
   logic                w_unused_cnt1;

   assign w_unused_cnt1 = io_bus.cnt1;
   assign w_last_iter   = (io_bus.cnt2 == CNT_W'(ITERATIONS - 1));

   // SRT digit selection from the top three partial-remainder bits
   function automatic logic [1:0] f_digit(input logic [2:0] a);
      logic [1:0] q;
      case (a)
         3'b001, 3'b010, 3'b011: q = Q_POS;
         3'b100, 3'b101, 3'b110: q = Q_NEG;
         default:                q = Q_ZERO;
      endcase
      return q;
   endfunction

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         r_state <= S_IDLE;
         r_q     <= Q_ZERO;
         r_c     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_c     <= w_c_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_dz    <= w_dz_nxt;
      end
   end

   // Outputs are registered copies of the decode of the state being entered, so they
   // track the state register exactly while leaving no input-to-output path.
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_c_nxt     = '0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_dz_nxt    = 1'b0;

      case (r_state)
         S_IDLE:   w_state_nxt = io_bus.start ? S_LOAD1 : S_IDLE;
         S_LOAD1:  w_state_nxt = S_LOAD2;
         S_LOAD2:  w_state_nxt = S_NORM;
         S_NORM:   w_state_nxt = S_CHKM;
         S_CHKM:   w_state_nxt = io_bus.m7 ? S_DECIDE : S_DZERO;
         S_DECIDE: begin
            w_q_nxt     = f_digit(io_bus.ctrl_bits);
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT:  w_state_nxt = (r_q == Q_ZERO) ? S_COUNT : S_ADDSUB;
         S_ADDSUB: w_state_nxt = S_COUNT;
         S_COUNT:  w_state_nxt = w_last_iter ? S_CORR : S_DECIDE;
         S_CORR:   w_state_nxt = S_QFORM;
         S_QFORM:  w_state_nxt = S_UNNORM;
         S_UNNORM: w_state_nxt = S_OUT1;
         S_OUT1:   w_state_nxt = S_OUT2;
         S_OUT2:   w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         S_DZERO:  w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase

      // The remainder is stable from the last COUNT through CORR, so its sign is taken
      // on the way into CORR.
      case (w_state_nxt)
         S_LOAD1:  w_c_nxt[C_LOAD1] = 1'b1;
         S_LOAD2:  w_c_nxt[C_LOAD2] = 1'b1;
         S_NORM:   w_c_nxt[C_NORM]  = 1'b1;
         S_SHIFT: begin
            w_c_nxt[C_SHIFT] = 1'b1;
            w_c_nxt[C_ADDM]  = (w_q_nxt == Q_NEG);
            w_c_nxt[C_SUBM]  = (w_q_nxt == Q_POS);
         end
         S_ADDSUB: begin
            w_c_nxt[C_ADDM] = (w_q_nxt == Q_NEG);
            w_c_nxt[C_SUBM] = (w_q_nxt == Q_POS);
         end
         S_COUNT:  w_c_nxt[C_COUNT] = 1'b1;
         S_CORR: begin
            w_c_nxt[C_CORR_A] = io_bus.ctrl_bits[2];
            w_c_nxt[C_CORR_B] = io_bus.ctrl_bits[2];
         end
         S_QFORM: begin
            w_c_nxt[C_CORR_A] = 1'b1;
            w_c_nxt[C_QFORM]  = 1'b1;
            w_c_nxt[C_QSEL]   = 1'b1;
         end
         S_UNNORM: w_c_nxt[C_UNNORM] = 1'b1;
         S_OUT1:   w_c_nxt[C_OUT1]   = 1'b1;
         S_OUT2:   w_c_nxt[C_OUT2]   = 1'b1;
         default:  w_c_nxt = '0;
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (w_state_nxt == S_DONE) || (w_state_nxt == S_DZERO);
      w_dz_nxt   = (w_state_nxt == S_DZERO);
   end

   assign io_bus.c    = r_c;
   assign io_bus.busy = r_busy;
   assign io_bus.done = r_done;
   assign io_bus.dz   = r_dz;

endmodule

// File: tb/tb_srt2_control_unit.sv
// Directed bench for srt2_control_unit: cycle traces per division checked against
// hand-computed pulse counts, latencies and control words.
module tb_srt2_control_unit;

   localparam int TR = 80;

   logic clk = 1'b0;
   logic rst_b;
   logic [2:0] m_cnt2;

   always #5 clk = ~clk;

   srt2_ctrl_if #(.CNT_W(3)) bus ();

   srt2_control_unit #(.ITERATIONS(8), .CNT_W(3)) dut (
      .clk    (clk),
      .rst_b  (rst_b),
      .io_bus (bus)
   );

   // Datapath iteration counter model: cleared by c0, incremented by c8
   always_ff @(posedge clk) begin
      if (bus.c[0])      m_cnt2 <= 3'd0;
      else if (bus.c[8]) m_cnt2 <= m_cnt2 + 3'd1;
   end
   assign bus.cnt2 = m_cnt2;

   int n_applied = 0;
   int n_miscomp = 0;

   logic [13:0] tr_c    [0:TR];
   logic        tr_busy [0:TR];
   logic        tr_done [0:TR];
   logic        tr_dz   [0:TR];

   typedef struct {
      string      name;
      logic       m7;
      logic [2:0] cb;
      int         done_cyc;
      int         dz;
      int         n_c3;
      int         n_c4;
      int         n_c5;
      int         n_c8;
      int         n_c9;
      int         n_c6;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input int act, input int exp);
      n_applied++;
      if (act !== exp) begin
         n_miscomp++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Caller sits at a negedge; cycle i of the trace is the i-th cycle after the start edge
   task automatic trace(input int n, input logic st, input int hold_until);
      bus.start = st;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         tr_c[i]    = bus.c;
         tr_busy[i] = bus.busy;
         tr_done[i] = bus.done;
         tr_dz[i]   = bus.dz;
         if (i >= hold_until) bus.start = 1'b0;
      end
   endtask

   function automatic int cnt_bit(input int b, input int n);
      int s = 0;
      for (int i = 1; i <= n; i++) if (tr_c[i][b]) s++;
      return s;
   endfunction

   function automatic int next_done(input int from, input int n);
      for (int i = from; i <= n; i++) if (tr_done[i]) return i;
      return -1;
   endfunction

   initial begin
      vecs[0] = '{"dz_m7_0",  1'b0, 3'b000,  5, 1, 0,  0,  0, 0, 0, 0};
      vecs[1] = '{"q0_000",   1'b1, 3'b000, 34, 0, 8,  0,  0, 8, 0, 1};
      vecs[2] = '{"qp_010",   1'b1, 3'b010, 42, 0, 8,  0, 16, 8, 0, 1};
      vecs[3] = '{"qn_101",   1'b1, 3'b101, 42, 0, 8, 16,  0, 8, 1, 2};
      vecs[4] = '{"q0_111",   1'b1, 3'b111, 34, 0, 8,  0,  0, 8, 1, 2};
      vecs[5] = '{"qp_011",   1'b1, 3'b011, 42, 0, 8,  0, 16, 8, 0, 1};
      vecs[6] = '{"qn_110",   1'b1, 3'b110, 42, 0, 8, 16,  0, 8, 1, 2};

      bus.start     = 1'b0;
      bus.cnt1      = 1'b0;
      bus.m7        = 1'b0;
      bus.ctrl_bits = 3'b000;
      rst_b         = 1'b0;
      #1 rst_b      = 1'b1;
      @(negedge clk);
      chk("reset_c",    int'(bus.c),    0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_dz",   int'(bus.dz),   0);
      rst_b = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         int dc;
         int dref;
         int both;
         bus.m7        = vecs[v].m7;
         bus.ctrl_bits = vecs[v].cb;
         trace(60, 1'b1, 1);
         dc   = next_done(1, 60);
         dref = (dc > 0 && dc < 60) ? dc : 1;
         both = 0;
         for (int i = 1; i <= 60; i++) if (tr_c[i][4] && tr_c[i][5]) both++;
         chk({vecs[v].name, "_done_cyc"}, dc, vecs[v].done_cyc);
         chk({vecs[v].name, "_dz"},       int'(tr_dz[dref]), vecs[v].dz);
         chk({vecs[v].name, "_busy_at_done"}, int'(tr_busy[dref]), 1);
         chk({vecs[v].name, "_busy_after"},   int'(tr_busy[dref + 1]), 0);
         chk({vecs[v].name, "_n_c0"},  cnt_bit(0, 60), 1);
         chk({vecs[v].name, "_n_c3"},  cnt_bit(3, 60), vecs[v].n_c3);
         chk({vecs[v].name, "_n_c4"},  cnt_bit(4, 60), vecs[v].n_c4);
         chk({vecs[v].name, "_n_c5"},  cnt_bit(5, 60), vecs[v].n_c5);
         chk({vecs[v].name, "_n_c8"},  cnt_bit(8, 60), vecs[v].n_c8);
         chk({vecs[v].name, "_n_c9"},  cnt_bit(9, 60), vecs[v].n_c9);
         chk({vecs[v].name, "_n_c6"},  cnt_bit(6, 60), vecs[v].n_c6);
         chk({vecs[v].name, "_n_c13"}, cnt_bit(13, 60), (vecs[v].dz != 0) ? 0 : 1);
         chk({vecs[v].name, "_c4c5_both"}, both, 0);
      end

      // Negative digits throughout: exact words for the first iteration and the tail
      bus.m7        = 1'b1;
      bus.ctrl_bits = 3'b101;
      trace(44, 1'b1, 1);
      chk("neg_shift_word",  int'(tr_c[6]),  'h0018);
      chk("neg_addsub_word", int'(tr_c[7]),  'h0010);
      chk("neg_count_word",  int'(tr_c[8]),  'h0100);
      chk("neg_corr_word",   int'(tr_c[37]), 'h0240);
      chk("neg_qform_word",  int'(tr_c[38]), 'h04C0);
      chk("neg_unnorm_word", int'(tr_c[39]), 'h0800);
      chk("neg_out1_word",   int'(tr_c[40]), 'h1000);
      chk("neg_out2_word",   int'(tr_c[41]), 'h2000);
      chk("neg_done_word",   int'(tr_c[42]), 'h0000);
      chk("neg_done_flag",   int'(tr_done[42]), 1);

      // Positive digits: first iteration words
      bus.ctrl_bits = 3'b010;
      trace(44, 1'b1, 1);
      chk("pos_shift_word",  int'(tr_c[6]), 'h0028);
      chk("pos_addsub_word", int'(tr_c[7]), 'h0020);

      // Asynchronous reset during the third ADDSUB
      trace(15, 1'b1, 1);
      chk("rst_pre_word", int'(tr_c[15]), 'h0020);
      #1 rst_b = 1'b1;
      #1;
      chk("rst_mid_c",    int'(bus.c),    0);
      chk("rst_mid_busy", int'(bus.busy), 0);
      @(negedge clk);
      rst_b = 1'b0;
      trace(12, 1'b0, 1);
      begin
         int nb = 0;
         int nc = 0;
         for (int i = 1; i <= 12; i++) begin
            if (tr_busy[i])     nb++;
            if (tr_c[i] != '0)  nc++;
         end
         chk("rst_after_busy_cycles", nb, 0);
         chk("rst_after_c_cycles",    nc, 0);
      end

      // start held high across a whole division, then dropped
      bus.ctrl_bits = 3'b000;
      trace(75, 1'b1, 36);
      chk("hold_first_done",  next_done(1, 75), 34);
      chk("hold_idle_busy",   int'(tr_busy[35]), 0);
      chk("hold_relaunch_c0", int'(tr_c[36]), 'h0001);
      chk("hold_second_done", next_done(35, 75), 69);
      chk("hold_n_c0",        cnt_bit(0, 75), 2);
      chk("hold_busy_end",    int'(tr_busy[75]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscomp);
      $finish;
   end

endmodule
